// File: rtl/fc_layer_link_if.sv
// Link bundle between an fc_layer output stream and the next layer's ibuf.
// master: the link (drives busy/ibuf/start/drop); slave: the surrounding stages.
interface fc_layer_link_if #(
  parameter int output_size   = 784,
  parameter int datatype_size = 4,
  parameter int func_width    = 4
);
  localparam int aw = (output_size > 1) ? $clog2(output_size) : 1;

  logic                     i_func_valid;
  logic [func_width-1:0]    i_func_data;
  logic                     o_busy;
  logic                     o_ibuf_we;
  logic [aw-1:0]            o_ibuf_addr;
  logic [datatype_size-1:0] o_ibuf_wr_data;
  logic                     o_start;
  logic                     i_dn_busy;
  logic                     o_drop;

  modport master (
    input  i_func_valid, i_func_data, i_dn_busy,
    output o_busy, o_ibuf_we, o_ibuf_addr,
    output o_ibuf_wr_data, o_start, o_drop
  );

  modport slave (
    output i_func_valid, i_func_data, i_dn_busy,
    input  o_busy, o_ibuf_we, o_ibuf_addr,
    input  o_ibuf_wr_data, o_start, o_drop
  );
endinterface

// File: rtl/fc_layer_link.sv
// Layer-to-layer link: shift/clamp activations, fill next ibuf, pulse start.
// Ports: clk, rst (sync, active-low), lnk (fc_layer_link_if.master).
module fc_layer_link #(
  parameter int output_size   = 784,
  parameter int datatype_size = 4,
  parameter int func_width    = 4,
  parameter int shift         = 0,
  parameter int relu          = 1
) (
  input  logic           clk,
  input  logic           rst,
  fc_layer_link_if.master lnk
);
  localparam int aw = (output_size > 1) ? $clog2(output_size) : 1;
  localparam logic [aw-1:0] last = aw'(output_size - 1);
  localparam logic signed [31:0] maxv = 32'(2**datatype_size - 1);
  // Unsigned target: the floor is 0 with or without relu.
  localparam logic signed [31:0] minv = (relu != 0) ? 32'sd0 : 32'sd0;

  typedef enum logic [1:0] {RECV, WAIT, START, ACK} state_t;

  state_t                   state, state_n;
  logic [aw-1:0]            count, count_n;
  logic [1:0]               tmr, tmr_n;
  logic                     retry, retry_n;
  logic                     accept;
  logic signed [31:0]       v_ext, v;
  logic [datatype_size-1:0] clamped;

  assign lnk.o_busy  = rst && ((state != RECV) || lnk.i_dn_busy);
  assign lnk.o_start = (state == START);
  assign accept      = lnk.i_func_valid && !lnk.o_busy;

  always_comb begin
    v_ext = signed'({{(32-func_width){lnk.i_func_data[func_width-1]}},
                     lnk.i_func_data});
    v = v_ext >>> shift;
    if (v < minv)
      clamped = '0;
    else if (v > maxv)
      clamped = datatype_size'(maxv);
    else
      clamped = v[datatype_size-1:0];
  end

  always_comb begin
    state_n = state;
    count_n = count;
    tmr_n   = tmr;
    retry_n = retry;
    unique case (state)
      RECV: begin
        if (accept) begin
          if (count == last) begin
            count_n = '0;
            state_n = WAIT;
          end else begin
            count_n = count + aw'(1);
          end
        end
      end
      WAIT: begin
        if (!lnk.i_dn_busy) state_n = START;
      end
      START: begin
        state_n = ACK;
        tmr_n   = '0;
      end
      ACK: begin
        if (lnk.i_dn_busy) begin
          state_n = RECV;
          retry_n = 1'b0;
        end else if (tmr == 2'd3) begin
          // One re-pulse if the start was missed, then give up.
          if (retry) begin
            state_n = RECV;
            retry_n = 1'b0;
          end else begin
            state_n = START;
            retry_n = 1'b1;
          end
        end else begin
          tmr_n = tmr + 2'd1;
        end
      end
      default: state_n = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= RECV;
      count              <= '0;
      tmr                <= '0;
      retry              <= 1'b0;
      lnk.o_ibuf_we      <= 1'b0;
      lnk.o_ibuf_addr    <= '0;
      lnk.o_ibuf_wr_data <= '0;
      lnk.o_drop         <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      tmr           <= tmr_n;
      retry         <= retry_n;
      lnk.o_ibuf_we <= accept;
      if (accept) begin
        lnk.o_ibuf_addr    <= count;
        lnk.o_ibuf_wr_data <= clamped;
      end
      if (lnk.i_func_valid && lnk.o_busy)
        lnk.o_drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fc_layer_link.sv
// Directed bench for fc_layer_link: two instances (4-bit and 8-bit/shift 2).
// Checks reset, writes, clamp, stall, retry, drop and mid-vector reset.
module tb_fc_layer_link;
  logic clk = 1'b0;
  logic rst;
  int   n  = 0;
  int   nf = 0;

  always #5 clk = ~clk;

  fc_layer_link_if #(.output_size(4)) a ();
  fc_layer_link_if #(.output_size(4), .func_width(8)) b ();

  fc_layer_link #(.output_size(4)) dut_a (
    .clk(clk), .rst(rst), .lnk(a)
  );
  fc_layer_link #(.output_size(4), .func_width(8), .shift(2)) dut_b (
    .clk(clk), .rst(rst), .lnk(b)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Four elements, first in d[3:0]; expects one write per cycle at addr 0..3.
  task automatic vec_a(input logic [15:0] d, input logic [15:0] q,
                       input logic last_busy);
    for (int i = 0; i < 4; i++) begin
      a.i_func_valid = 1'b1;
      a.i_func_data  = d[i*4 +: 4];
      step;
      chk("vec_we",   a.o_ibuf_we, 1);
      chk("vec_addr", a.o_ibuf_addr, i);
      chk("vec_data", a.o_ibuf_wr_data, q[i*4 +: 4]);
    end
    a.i_func_valid = 1'b0;
    a.i_dn_busy    = last_busy;
    #1;
    chk("vec_wait_busy", a.o_busy, 1);
    chk("vec_wait_nostart", a.o_start, 0);
  endtask

  logic [7:0] bd [4];
  logic [3:0] bq [4];

  initial begin
    bd = '{8'hEC, 8'h0D, 8'h7F, 8'h40};
    bq = '{4'h0, 4'h3, 4'hF, 4'hF};
    rst = 1'b0;
    a.i_func_valid = 1'b1;
    a.i_func_data  = 4'h5;
    a.i_dn_busy    = 1'b0;
    b.i_func_valid = 1'b1;
    b.i_func_data  = 8'h11;
    b.i_dn_busy    = 1'b0;

    repeat (3) step;
    chk("rst_we",    a.o_ibuf_we, 0);
    chk("rst_addr",  a.o_ibuf_addr, 0);
    chk("rst_data",  a.o_ibuf_wr_data, 0);
    chk("rst_start", a.o_start, 0);
    chk("rst_drop",  a.o_drop, 0);
    chk("rst_busy",  a.o_busy, 0);
    chk("rst_b_we",  b.o_ibuf_we, 0);
    chk("rst_b_drop", b.o_drop, 0);
    b.i_func_valid = 1'b0;

    rst = 1'b1;
    a.i_func_data = 4'h1;
    #1;
    chk("idle_busy", a.o_busy, 0);
    vec_a(16'h4321, 16'h4321, 1'b0);
    step;
    chk("t2_start", a.o_start, 1);
    chk("t2_we_off", a.o_ibuf_we, 0);
    a.i_dn_busy = 1'b1;
    step;
    chk("t2_start_once", a.o_start, 0);
    chk("t2_ack_busy", a.o_busy, 1);
    step;
    a.i_dn_busy = 1'b0;
    #1;
    chk("t2_recv", a.o_busy, 0);
    chk("t2_nodrop", a.o_drop, 0);

    vec_a(16'hA987, 16'h0007, 1'b1);
    step;
    chk("t4_hold_start", a.o_start, 0);
    chk("t4_hold_busy", a.o_busy, 1);
    chk("t4_hold_we", a.o_ibuf_we, 0);
    step;
    chk("t4_hold2", a.o_start, 0);
    a.i_dn_busy = 1'b0;
    step;
    chk("t4_start", a.o_start, 1);
    step;
    chk("t4_start_once", a.o_start, 0);
    a.i_dn_busy = 1'b1;
    step;
    a.i_dn_busy = 1'b0;
    #1;
    chk("t4_recv", a.o_busy, 0);

    vec_a(16'h5656, 16'h5656, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      step;
      if (k == 11)
        chk("retry_recv", a.o_busy, 0);
      chk("retry_start", a.o_start, (k == 1 || k == 6) ? 1 : 0);
    end

    a.i_dn_busy    = 1'b1;
    a.i_func_valid = 1'b1;
    a.i_func_data  = 4'h3;
    step;
    chk("drop_we", a.o_ibuf_we, 0);
    chk("drop_set", a.o_drop, 1);
    a.i_func_valid = 1'b0;
    a.i_dn_busy    = 1'b0;
    vec_a(16'h1234, 16'h1234, 1'b0);
    chk("drop_sticky", a.o_drop, 1);
    step;
    a.i_dn_busy = 1'b1;
    step;
    step;
    a.i_dn_busy = 1'b0;
    #1;
    chk("drop_sticky2", a.o_drop, 1);

    rst = 1'b0;
    step;
    chk("drop_clear", a.o_drop, 0);
    rst = 1'b1;
    a.i_func_valid = 1'b1;
    a.i_func_data  = 4'h1;
    step;
    a.i_func_data  = 4'h2;
    step;
    chk("part_addr1", a.o_ibuf_addr, 1);
    rst = 1'b0;
    a.i_func_valid = 1'b0;
    step;
    chk("abort_we", a.o_ibuf_we, 0);
    chk("abort_addr", a.o_ibuf_addr, 0);
    chk("abort_start", a.o_start, 0);
    rst = 1'b1;
    vec_a(16'h6543, 16'h6543, 1'b0);
    step;
    chk("t6_start", a.o_start, 1);
    a.i_dn_busy = 1'b1;
    step;
    chk("t6_start_once", a.o_start, 0);
    step;
    a.i_dn_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("t6_no_more_start", a.o_start, 0);
    end

    for (int i = 0; i < 4; i++) begin
      b.i_func_valid = 1'b1;
      b.i_func_data  = bd[i];
      step;
      chk("clamp_we",   b.o_ibuf_we, 1);
      chk("clamp_addr", b.o_ibuf_addr, i);
      chk("clamp_data", b.o_ibuf_wr_data, bq[i]);
    end
    b.i_func_valid = 1'b0;
    #1;
    chk("clamp_wait_busy", b.o_busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
    $finish;
  end
endmodule
